alien_bomb_ctrl: RTL and testbench

Enemy-fire controller for the invaders playfield, complementing the player bullet logic. It periodically picks a random alien column, then launches a bomb from the lowest surviving alien in that column. It drops up to `NumBombs` bombs toward the player, detects bomb/player overlap, and maintains the player's lives and game-over state. It reads the same alien formation origin and `Aliens_Grid` that the player-bullet block produces.

---
 rtl/alien_bomb_ctrl_if.sv | 30 +++
 rtl/alien_bomb_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_alien_bomb_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alien_bomb_ctrl_if.sv
// Playfield-to-enemy-fire bundle: formation/player positions in, bomb slots and lives out.
interface alien_bomb_ctrl_if #(
  parameter int NumBombs = 3
);
  logic                    Tick;
  logic                    Clear;
  logic [8:0]              Aliens_Row;
  logic [9:0]              Aliens_Col;
  logic [49:0]             Aliens_Grid;
  logic [8:0]              Player_Row;
  logic [9:0]              Player_Col;
  logic [9*NumBombs-1:0]   Bomb_Rows;
  logic [10*NumBombs-1:0]  Bomb_Cols;
  logic [NumBombs-1:0]     Bomb_Active;
  logic                    Player_Hit;
  logic [1:0]              Lives;
  logic                    Game_Over;

  // Game side: supplies geometry and strobes, consumes bomb state.
  modport master (
    output Tick, Clear, Aliens_Row, Aliens_Col, Aliens_Grid, Player_Row, Player_Col,
    input  Bomb_Rows, Bomb_Cols, Bomb_Active, Player_Hit, Lives, Game_Over
  );

  // Enemy-fire controller side.
  modport slave (
    input  Tick, Clear, Aliens_Row, Aliens_Col, Aliens_Grid, Player_Row, Player_Col,
    output Bomb_Rows, Bomb_Cols, Bomb_Active, Player_Hit, Lives, Game_Over
  );
endinterface

// File: rtl/alien_bomb_ctrl.sv
// Enemy-fire controller: picks a random column, drops a bomb from its lowest
// living alien, moves bombs each frame, and tracks player hits and lives.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | count Ticks toward the next fire attempt; wait for a free slot
// S_SELECT | draw LFSR nibbles until one names a valid column (0-9)
// S_SEARCH | walk the chosen column from the bottom row up, one row per cycle
// S_LAUNCH | load the lowest free slot with the alien's bomb position
module alien_bomb_ctrl #(
  parameter int          NumBombs     = 3,
  parameter int          FireInterval = 24,
  parameter int          BombSpeed    = 6,
  parameter int          InitLives    = 3,
  parameter logic [7:0]  LfsrSeed     = 8'hA5,
  parameter int          AlienWidth   = 30,
  parameter int          AlienHeight  = 20,
  parameter int          AlienPitchX  = 40,
  parameter int          AlienPitchY  = 30,
  parameter int          PlayerWidth  = 30,
  parameter int          PlayerHeight = 20,
  parameter int          BombWidth    = 4,
  parameter int          BombHeight   = 8
) (
  input logic               Clk,
  input logic               Reset,
  alien_bomb_ctrl_if.slave  bus
);

  localparam int              CntW   = (FireInterval > 1) ? $clog2(FireInterval) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FireInterval - 1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_SEARCH, S_LAUNCH} state_t;

  state_t              r_state;
  logic [CntW-1:0]     r_cnt;
  logic [3:0]          r_col;
  logic [2:0]          r_row;
  logic [7:0]          r_lfsr;
  logic [8:0]          r_bomb_row [NumBombs];
  logic [9:0]          r_bomb_col [NumBombs];
  logic [NumBombs-1:0] r_active;
  logic                r_hit;
  logic [1:0]          r_lives;
  logic                r_game_over;

  logic [NumBombs-1:0]   w_hit_vec;
  logic [9:0]            w_moved [NumBombs];
  logic                  w_hit_any;
  logic                  w_go_next;
  logic                  w_abort;
  logic                  w_any_free;
  logic [1:0]            w_free_idx;
  logic [CntW-1:0]       w_cnt_next;
  logic                  w_launch;
  logic [8:0]            w_launch_row;
  logic [9:0]            w_launch_col;
  logic [5:0]            w_grid_idx;
  logic [9*NumBombs-1:0]  w_rows;
  logic [10*NumBombs-1:0] w_cols;

  // Per-slot overlap against the player (pre-move position) and next row.
  always_comb begin
    w_hit_vec = '0;
    for (int i = 0; i < NumBombs; i++) begin
      w_moved[i]   = {1'b0, r_bomb_row[i]} + 10'(BombSpeed);
      w_hit_vec[i] = bus.Tick && r_active[i] &&
        ({1'b0, r_bomb_col[i]} < {1'b0, bus.Player_Col} + 11'(PlayerWidth)) &&
        ({1'b0, r_bomb_col[i]} + 11'(BombWidth) > {1'b0, bus.Player_Col}) &&
        ({1'b0, r_bomb_row[i]} < {1'b0, bus.Player_Row} + 10'(PlayerHeight)) &&
        ({1'b0, r_bomb_row[i]} + 10'(BombHeight) > {1'b0, bus.Player_Row});
    end
  end

  // Lowest-index free slot; scanning downward leaves the smallest index last.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = NumBombs - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_any_free = 1'b1;
        w_free_idx = 2'(i);
      end
    end
  end

  // Saturating fire-interval count for this cycle.
  always_comb begin
    if (bus.Tick && r_cnt != CntMax) w_cnt_next = r_cnt + CntW'(1);
    else                             w_cnt_next = r_cnt;
  end

  // Pack slot registers onto the flat output buses.
  always_comb begin
    w_rows = '0;
    w_cols = '0;
    for (int i = 0; i < NumBombs; i++) begin
      w_rows[i*9 +: 9]   = r_bomb_row[i];
      w_cols[i*10 +: 10] = r_bomb_col[i];
    end
  end

  // Several simultaneous overlaps still count as one hit.
  assign w_hit_any    = (|w_hit_vec) && !bus.Clear && !r_game_over;
  assign w_go_next    = w_hit_any && (r_lives == 2'd1);
  assign w_abort      = bus.Clear || r_game_over || w_go_next;
  assign w_launch     = (r_state == S_LAUNCH) && !w_abort;
  assign w_grid_idx   = 6'(int'(r_row) * 10 + int'(r_col));
  assign w_launch_col = bus.Aliens_Col +
                        10'(int'(r_col) * AlienPitchX + AlienWidth / 2 - BombWidth / 2);
  assign w_launch_row = bus.Aliens_Row + 9'(int'(r_row) * AlienPitchY + AlienHeight);

  assign bus.Bomb_Rows   = w_rows;
  assign bus.Bomb_Cols   = w_cols;
  assign bus.Bomb_Active = r_active;
  assign bus.Player_Hit  = r_hit;
  assign bus.Lives       = r_lives;
  assign bus.Game_Over   = r_game_over;

  // Free-running column randomiser; only reset stops it.
  always_ff @(posedge Clk) begin
    if (Reset) r_lfsr <= LfsrSeed;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  // Fire-attempt sequencer: interval count, column pick, bottom-up search.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= w_cnt_next;
          if (w_cnt_next == CntMax && w_any_free) r_state <= S_SELECT;
        end
        S_SELECT: begin
          if (r_lfsr[3:0] <= 4'd9) begin
            r_col   <= r_lfsr[3:0];
            r_row   <= 3'd4;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (bus.Aliens_Grid[w_grid_idx]) begin
            r_state <= S_LAUNCH;
          end else if (r_row == 3'd0) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_row <= r_row - 3'd1;
          end
        end
        S_LAUNCH: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bomb slots, hit pulse, lives and the terminal game-over freeze.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_active    <= '0;
      r_hit       <= 1'b0;
      r_lives     <= 2'(InitLives);
      r_game_over <= 1'b0;
      for (int i = 0; i < NumBombs; i++) begin
        r_bomb_row[i] <= 9'd500;
        r_bomb_col[i] <= '0;
      end
    end else begin
      r_hit <= 1'b0;
      if (!r_game_over) begin
        if (bus.Clear) begin
          r_active <= '0;
          for (int i = 0; i < NumBombs; i++) r_bomb_row[i] <= 9'd500;
        end else begin
          if (w_hit_any) begin
            r_hit   <= 1'b1;
            r_lives <= r_lives - 2'd1;
            if (w_go_next) r_game_over <= 1'b1;
          end
          for (int i = 0; i < NumBombs; i++) begin
            if (w_go_next || w_hit_vec[i]) begin
              r_active[i]   <= 1'b0;
              r_bomb_row[i] <= 9'd500;
            end else if (r_active[i] && bus.Tick) begin
              if (w_moved[i] >= 10'd480) begin
                r_active[i]   <= 1'b0;
                r_bomb_row[i] <= 9'd500;
              end else begin
                r_bomb_row[i] <= w_moved[i][8:0];
              end
            end else if (w_launch && int'(w_free_idx) == i) begin
              r_active[i]   <= 1'b1;
              r_bomb_row[i] <= w_launch_row;
              r_bomb_col[i] <= w_launch_col;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alien_bomb_ctrl.sv
// Randomised bench for alien_bomb_ctrl with a fire-attempt-level reference model.
module tb_alien_bomb_ctrl;
  localparam int NB   = 3;
  localparam int FI   = 2;
  localparam int SPD  = 6;
  localparam int IL   = 3;
  localparam int SEED = 8'hA5;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  alien_bomb_ctrl_if #(.NumBombs(NB)) bus ();

  alien_bomb_ctrl #(.NumBombs(NB), .FireInterval(FI)) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_valid = 0;
  int m_cyc   = 0;
  int m_lfsr, m_cnt, m_lives;
  bit m_hit, m_go;
  bit m_act [NB];
  int m_row [NB];
  int m_col [NB];
  // A pending fire attempt is resolved in advance: when it ends and what it does.
  bit m_att;
  int m_res_cyc, m_res_c, m_res_r, m_srch_lo, m_srch_hi;
  bit m_res_launch;

  function automatic int lfsr_step(int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  function automatic bit overlap(int br, int bc, int pr, int pc);
    return (bc < pc + 30) && (bc + 4 > pc) && (br < pr + 20) && (br + 8 > pr);
  endfunction

  // Attempt starting at cycle n: select from cycle n+1 on, search bottom-up.
  task automatic plan_attempt(int n);
    int l, s, g;
    l = m_lfsr; s = n + 1; g = 0;
    while ((l & 15) > 9 && g < 300) begin l = lfsr_step(l); s++; g++; end
    m_att = 1; m_res_c = l & 15; m_res_launch = 0;
    m_srch_lo = s + 1; m_srch_hi = s + 5; m_res_cyc = s + 5;
    for (int r = 4; r >= 0; r--) begin
      if (bus.Aliens_Grid[r*10 + m_res_c]) begin
        m_res_launch = 1; m_res_r = r;
        m_srch_hi = s + 1 + (4 - r);
        m_res_cyc = m_srch_hi + 1;
        break;
      end
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < NB; i++) begin m_act[i] = 0; m_row[i] = 500; end
  endtask

  always @(posedge Clk) begin : model
    int free_idx, hits, cn;
    bit start_act [NB];
    if (Reset) begin
      m_valid = 1; m_lfsr = SEED; m_cnt = 0; m_att = 0;
      m_hit = 0; m_lives = IL; m_go = 0;
      clear_slots();
      for (int i = 0; i < NB; i++) m_col[i] = 0;
    end else if (m_valid) begin
      m_lfsr = lfsr_step(m_lfsr);
      m_hit  = 0;
      if (!m_go) begin
        if (bus.Clear) begin
          clear_slots(); m_cnt = 0; m_att = 0;
        end else begin
          free_idx = -1;
          for (int i = 0; i < NB; i++) begin
            start_act[i] = m_act[i];
            if (!m_act[i] && free_idx < 0) free_idx = i;
          end
          hits = 0;
          if (bus.Tick) begin
            for (int i = 0; i < NB; i++) begin
              if (start_act[i]) begin
                if (overlap(m_row[i], m_col[i], bus.Player_Row, bus.Player_Col)) begin
                  hits++; m_act[i] = 0; m_row[i] = 500;
                end else if (m_row[i] + SPD >= 480) begin
                  m_act[i] = 0; m_row[i] = 500;
                end else begin
                  m_row[i] = m_row[i] + SPD;
                end
              end
            end
          end
          if (hits > 0) begin
            m_hit = 1; m_lives--;
            if (m_lives == 0) begin m_go = 1; clear_slots(); m_att = 0; m_cnt = 0; end
          end
          if (!m_go) begin
            if (m_att) begin
              if (m_cyc == m_res_cyc) begin
                m_att = 0; m_cnt = 0;
                if (m_res_launch && free_idx >= 0) begin
                  m_act[free_idx] = 1;
                  m_col[free_idx] = (int'(bus.Aliens_Col) + m_res_c * 40 + 13) % 1024;
                  m_row[free_idx] = (int'(bus.Aliens_Row) + m_res_r * 30 + 20) % 512;
                end
              end
            end else begin
              cn = (bus.Tick && m_cnt < FI - 1) ? m_cnt + 1 : m_cnt;
              m_cnt = cn;
              if (cn == FI - 1 && free_idx >= 0) plan_attempt(m_cyc);
            end
          end
        end
      end
    end
    m_cyc++;
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (m_valid) begin
      for (int i = 0; i < NB; i++) begin
        chk($sformatf("active[%0d]", i), bus.Bomb_Active[i], m_act[i]);
        chk($sformatf("row[%0d]", i), bus.Bomb_Rows[i*9 +: 9], m_row[i]);
        if (m_act[i]) chk($sformatf("col[%0d]", i), bus.Bomb_Cols[i*10 +: 10], m_col[i]);
      end
      chk("player_hit", bus.Player_Hit, m_hit);
      chk("lives", bus.Lives, m_lives);
      chk("game_over", bus.Game_Over, m_go);
    end
  end

  // ---------------- stimulus ----------------
  int tick_ctr = 0;
  bit rnd_tick = 0, rnd_clear = 0, rnd_player = 0;

  task automatic step();
    @(posedge Clk);
    #1;
    bus.Tick  = rnd_tick ? ($urandom_range(0, 2) == 0) : (tick_ctr % 2 == 0);
    tick_ctr++;
    bus.Clear = rnd_clear && ($urandom_range(0, 149) == 0);
    if (rnd_player && $urandom_range(0, 15) == 0) bus.Player_Col = 10'($urandom_range(0, 700));
  endtask

  task automatic do_reset(logic [49:0] grid);
    Reset = 1'b1;
    bus.Aliens_Grid = grid;
    step();
    step();
    Reset = 1'b0;
  endtask

  function automatic logic [NB-1:0] lowest_zero(logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (!v[i]) return NB'(1) << i;
    return '0;
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [49:0] g43, g3, gtmp;
    logic [63:0] r64;
    logic [NB-1:0] prev_act, new_bits;
    int t, last_row0;
    bit any_hit;

    bus.Tick = 0; bus.Clear = 0;
    bus.Aliens_Row = 9'd40; bus.Aliens_Col = 10'd100; bus.Aliens_Grid = '0;
    bus.Player_Row = 9'd440; bus.Player_Col = 10'd220;
    g43 = '0; g43[43] = 1'b1;
    g3  = '0; g3[3]   = 1'b1;

    // Reset values
    do_reset(g43);
    chk("rst_active", bus.Bomb_Active, 0);
    chk("rst_row0", bus.Bomb_Rows[8:0], 500);
    chk("rst_row2", bus.Bomb_Rows[26:18], 500);
    chk("rst_lives", bus.Lives, 3);
    chk("rst_game_over", bus.Game_Over, 0);
    chk("rst_hit", bus.Player_Hit, 0);

    // Single alien at r4,c3: first launch position
    t = 0;
    while (!bus.Bomb_Active[0] && t < 300) begin step(); t++; end
    chk("launch_in_time", t < 300, 1);
    chk("launch_slot", bus.Bomb_Active, 1);
    chk("launch_col", bus.Bomb_Cols[9:0], 233);
    chk("launch_row", bus.Bomb_Rows[8:0], 180);

    // Player hit on the first Tick with pre-move row > 432
    last_row0 = bus.Bomb_Rows[8:0];
    prev_act  = bus.Bomb_Active;
    t = 0;
    while (!bus.Player_Hit && t < 600) begin
      step(); t++;
      new_bits = bus.Bomb_Active & ~prev_act;
      for (int i = 0; i < NB; i++)
        if (new_bits[i]) chk("launch_col_c3_only", bus.Bomb_Cols[i*10 +: 10], 233);
      prev_act = bus.Bomb_Active;
      if (!bus.Player_Hit && bus.Bomb_Active[0]) last_row0 = bus.Bomb_Rows[8:0];
    end
    chk("hit_in_time", t < 600, 1);
    chk("hit_lives", bus.Lives, 2);
    chk("hit_pre_move_row", last_row0, 438);
    chk("hit_slot0_cleared", bus.Bomb_Active[0], 0);
    step();
    chk("hit_one_cycle", bus.Player_Hit, 0);

    // Further hits end the game; no fire afterwards
    t = 0;
    while (!bus.Game_Over && t < 2000) begin step(); t++; end
    chk("game_over_in_time", t < 2000, 1);
    chk("go_lives", bus.Lives, 0);
    chk("go_slots_clear", bus.Bomb_Active, 0);
    for (int k = 0; k < 200; k++) begin
      step();
      chk("go_no_launch", bus.Bomb_Active, 0);
    end

    // Recovery from game over
    do_reset(g43);
    chk("recover_lives", bus.Lives, 3);
    chk("recover_game_over", bus.Game_Over, 0);

    // Miss: bomb falls off the bottom
    bus.Player_Col = 10'd300;
    do_reset(g43);
    t = 0;
    while (!bus.Bomb_Active[0] && t < 300) begin step(); t++; end
    chk("miss_launch_in_time", t < 300, 1);
    last_row0 = bus.Bomb_Rows[8:0];
    any_hit = 0; t = 0;
    while (bus.Bomb_Active[0] && t < 600) begin
      step(); t++;
      if (bus.Player_Hit) any_hit = 1;
      if (bus.Bomb_Active[0]) last_row0 = bus.Bomb_Rows[8:0];
    end
    chk("miss_exit_in_time", t < 600, 1);
    chk("miss_last_row", last_row0, 474);
    chk("miss_row_parked", bus.Bomb_Rows[8:0], 500);
    chk("miss_lives", bus.Lives, 3);
    chk("miss_no_hit", any_hit, 0);

    // Slot saturation and lowest-index refill
    bus.Player_Col = 10'd900;
    do_reset({50{1'b1}});
    t = 0;
    while (bus.Bomb_Active != 3'b111 && t < 1000) begin step(); t++; end
    chk("sat_full", bus.Bomb_Active, 7);
    prev_act = bus.Bomb_Active;
    new_bits = '0; t = 0;
    while (new_bits == '0 && t < 1000) begin
      step(); t++;
      new_bits = bus.Bomb_Active & ~prev_act;
      if (new_bits == '0) prev_act = bus.Bomb_Active;
    end
    chk("refill_in_time", t < 1000, 1);
    chk("refill_lowest", new_bits, int'(lowest_zero(prev_act)));

    // Empty grid: no launches
    do_reset('0);
    for (int k = 0; k < 400; k++) begin
      step();
      chk("empty_no_launch", bus.Bomb_Active, 0);
    end

    // Reset in the middle of a column search
    do_reset(g3);
    t = 0;
    while (!(m_att && m_cyc >= m_srch_lo && m_cyc <= m_srch_hi) && t < 300) begin step(); t++; end
    chk("search_reached", t < 300, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midsearch_lives", bus.Lives, 3);
    chk("midsearch_game_over", bus.Game_Over, 0);
    chk("midsearch_row0", bus.Bomb_Rows[8:0], 500);
    chk("midsearch_row1", bus.Bomb_Rows[17:9], 500);
    chk("midsearch_active", bus.Bomb_Active, 0);

    // Randomised episodes checked by the model
    rnd_tick = 1; rnd_clear = 1; rnd_player = 1;
    for (int ep = 0; ep < 8; ep++) begin
      r64  = {$urandom(), $urandom()};
      gtmp = r64[49:0];
      if (ep % 3 == 1) gtmp = gtmp & {$urandom(), $urandom()};
      bus.Aliens_Row = 9'($urandom_range(0, 250));
      bus.Aliens_Col = 10'($urandom_range(0, 300));
      bus.Player_Row = 9'($urandom_range(300, 460));
      bus.Player_Col = 10'($urandom_range(0, 700));
      do_reset(gtmp);
      for (int k = 0; k < 1500; k++) begin
        step();
        if ($urandom_range(0, 63) == 0) bus.Aliens_Col = 10'($urandom_range(0, 300));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
